// File: rtl/mmm_nlp_pkg.sv
// Shared constants and helpers for the NLP modular-multiply datapath.
// Used by the multiplier, its issue controller and the FIFO.
package mmm_nlp_pkg;

  localparam int IDW_DEF = 256;
  localparam int ODW_DEF = 512;
  localparam int LAT_DEF = 9;

  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mmm_nlp_sync_fifo.sv
// Synchronous FIFO, first-word-fall-through from a registered array.
// Writes to full and reads from empty are ignored.
module mmm_nlp_sync_fifo
  import mmm_nlp_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int CW   = cred_w(DEPTH),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rptr];

  // storage, wrapping pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= wr_data;
        wptr <= (wptr == PW'(DEPTH - 1)) ?
                '0 : wptr + PW'(1);
      end
      if (do_rd)
        rptr <= (rptr == PW'(DEPTH - 1)) ?
                '0 : rptr + PW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mmm_nlp_mul_issue_ctrl.sv
// Credit-based issue controller for the fixed-latency multiplier.
// Optional counters: define MMM_NLP_MUL_PERF_EN.
module mmm_nlp_mul_issue_ctrl
  import mmm_nlp_pkg::*;
#(
  parameter int IDW     = IDW_DEF,
  parameter int ODW     = ODW_DEF,
  parameter int LATENCY = LAT_DEF,
  parameter int DEPTH   = 4,
  parameter int TAGW    = 4,
  localparam int CW     = cred_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [IDW-1:0]  i_a,
  input  logic [IDW-1:0]  i_b,
  input  logic [TAGW-1:0] i_tag,
  output logic [IDW-1:0]  o_mul_a,
  output logic [IDW-1:0]  o_mul_b,
  input  logic [ODW-1:0]  i_mul_res,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [ODW-1:0]  o_res,
  output logic [TAGW-1:0] o_tag,
  output logic [CW-1:0]   o_credit
`ifdef MMM_NLP_MUL_PERF_EN
  ,
  output logic [31:0]     o_issue_cnt,
  output logic [31:0]     o_stall_cnt
`endif
);

  logic            issue;
  logic            pop;
  logic            empty;
  logic            full;
  logic [CW-1:0]   count;
  logic            unused;
  logic [LATENCY:0] vld;
  logic [TAGW-1:0] tag_p [LATENCY+1];

  assign o_ready = (o_credit != '0);
  assign issue   = i_valid && o_ready;
  assign o_valid = !empty;
  assign pop     = o_valid && i_ready;
  assign unused  = ^{full, count};

  // one credit per op from accept until the product is popped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      o_credit <= CW'(DEPTH);
    else
      unique case ({issue, pop})
        2'b10:   o_credit <= o_credit - CW'(1);
        2'b01:   o_credit <= o_credit + CW'(1);
        default: ;
      endcase
  end

  // operand registers hold until the next accepted pair
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_mul_a <= '0;
      o_mul_b <= '0;
    end else if (issue) begin
      o_mul_a <= i_a;
      o_mul_b <= i_b;
    end
  end

  // valid/tag pipe tracks ops through the multiplier
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
      for (int k = 0; k <= LATENCY; k++)
        tag_p[k] <= '0;
    end else begin
      vld      <= {vld[LATENCY-1:0], issue};
      tag_p[0] <= i_tag;
      for (int k = 1; k <= LATENCY; k++)
        tag_p[k] <= tag_p[k-1];
    end
  end

  mmm_nlp_sync_fifo #(
    .W     (ODW + TAGW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (vld[LATENCY]),
    .wr_data ({i_mul_res, tag_p[LATENCY]}),
    .rd_en   (pop),
    .rd_data ({o_res, o_tag}),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

`ifdef MMM_NLP_MUL_PERF_EN
  // saturating accept and stall counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_issue_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (issue && o_issue_cnt != '1)
        o_issue_cnt <= o_issue_cnt + 32'd1;
      if (i_valid && !o_ready && o_stall_cnt != '1)
        o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmm_nlp_mul_issue_ctrl.sv
// Bench for mmm_nlp_mul_issue_ctrl with a behavioural 9-cycle
// multiplier and a queue-based reference of issued products.
module tb_mmm_nlp_mul_issue_ctrl;

  localparam int LAT = 9;
  localparam int DEP = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         i_valid;
  logic         o_ready;
  logic [255:0] i_a;
  logic [255:0] i_b;
  logic [3:0]   i_tag;
  logic [255:0] o_mul_a;
  logic [255:0] o_mul_b;
  logic [511:0] i_mul_res;
  logic         o_valid;
  logic         i_ready;
  logic [511:0] o_res;
  logic [3:0]   o_tag;
  logic [2:0]   o_credit;
`ifdef MMM_NLP_MUL_PERF_EN
  logic [31:0]  o_issue_cnt;
  logic [31:0]  o_stall_cnt;
`endif

  always #5 clk = ~clk;

  mmm_nlp_mul_issue_ctrl #(
    .IDW(256), .ODW(512), .LATENCY(LAT),
    .DEPTH(DEP), .TAGW(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_tag(i_tag),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
    .i_mul_res(i_mul_res),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_res(o_res), .o_tag(o_tag),
    .o_credit(o_credit)
`ifdef MMM_NLP_MUL_PERF_EN
    ,
    .o_issue_cnt(o_issue_cnt),
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  // behavioural multiplier: product stable LAT edges after operands
  logic [511:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= {256'd0, o_mul_a} * {256'd0, o_mul_b};
    for (int k = 1; k < LAT; k++)
      mp[k] <= mp[k-1];
  end
  assign i_mul_res = mp[LAT-1];

  int checks = 0;
  int errors = 0;

  logic [511:0] q_res [$];
  logic [3:0]   q_tag [$];
  int           outstanding = 0;
  logic         issd, popd, sb_miss;
  logic [511:0] got_res, want_res;
  logic [3:0]   got_tag, want_tag;

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] mul(input logic [255:0] a,
                                       input logic [255:0] b);
    return {256'd0, a} * {256'd0, b};
  endfunction

  // records handshakes seen at the coming edge, then advances a cycle
  task automatic tick();
    issd    = i_valid && o_ready;
    popd    = o_valid && i_ready;
    sb_miss = 1'b0;
    if (popd) begin
      got_res = o_res;
      got_tag = o_tag;
      if (q_res.size() == 0) begin
        sb_miss = 1'b1;
      end else begin
        want_res = q_res.pop_front();
        want_tag = q_tag.pop_front();
      end
    end
    if (issd) begin
      q_res.push_back(mul(i_a, i_b));
      q_tag.push_back(i_tag);
    end
    outstanding += int'(issd) - int'(popd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_a = '0; i_b = '0; i_tag = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid got %0b want 0", o_valid); end
    checks++;
    if (o_ready !== 1'b1) begin errors++;
      $display("FAIL rst_ready got %0b want 1", o_ready); end
    checks++;
    if (o_credit !== 3'd4) begin errors++;
      $display("FAIL rst_credit got %0d want 4", o_credit); end
    checks++;
    if (o_res !== '0) begin errors++;
      $display("FAIL rst_res got %0h want 0", o_res); end
    checks++;
    if (o_tag !== '0) begin errors++;
      $display("FAIL rst_tag got %0h want 0", o_tag); end
    checks++;
    if (o_mul_a !== '0 || o_mul_b !== '0) begin errors++;
      $display("FAIL rst_mul got %0h/%0h want 0", o_mul_a, o_mul_b); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_drain(input string nm);
    int n = 0;
    i_valid = 1'b0; i_ready = 1'b1;
    while (outstanding > 0 && n < 80) begin
      tick();
      n++;
      if (popd) begin
        checks++;
        if (sb_miss || got_res !== want_res || got_tag !== want_tag) begin
          errors++;
          $display("FAIL %s_pop got %0h/%0h want %0h/%0h",
                   nm, got_res, got_tag, want_res, want_tag);
        end
      end
    end
    checks++;
    if (outstanding != 0 || o_credit !== 3'd4 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain got out=%0d credit=%0d valid=%0b want 0/4/0",
               nm, outstanding, o_credit, o_valid);
    end
  endtask

  task automatic test_single();
    logic [511:0] exp_res;
    logic [255:0] ones;
    ones = '1;
    exp_res = '0;
    exp_res = exp_res - (512'd1 << 257) + 512'd1;
    i_valid = 1'b1; i_ready = 1'b1;
    i_a = ones; i_b = ones; i_tag = 4'h5;
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_mul_a !== ones || o_credit !== 3'd3) begin errors++;
      $display("FAIL single_issue got %0h/%0d want %0h/3",
               o_mul_a, o_credit, ones); end
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      checks++;
      if (o_valid !== (k == LAT + 1)) begin errors++;
        $display("FAIL single_lat edge+%0d got %0b want %0b",
                 k, o_valid, (k == LAT + 1)); end
    end
    checks++;
    if (o_res !== exp_res || o_tag !== 4'h5) begin errors++;
      $display("FAIL single_res got %0h/%0h want %0h/5",
               o_res, o_tag, exp_res); end
    test_drain("single");
  endtask

  task automatic test_stream();
    int issued = 0;
    int n = 0;
    i_ready = 1'b1; i_valid = 1'b1;
    i_a = rnd256(); i_b = rnd256(); i_tag = 4'($urandom);
    while (issued < 100 && n < 2000) begin
      checks++;
      if (o_ready !== (outstanding < DEP)) begin errors++;
        $display("FAIL stream_ready got %0b want %0b",
                 o_ready, (outstanding < DEP)); end
      tick();
      n++;
      if (popd) begin
        checks++;
        if (sb_miss || got_res !== want_res || got_tag !== want_tag) begin
          errors++;
          $display("FAIL stream_pop got %0h/%0h want %0h/%0h",
                   got_res, got_tag, want_res, want_tag);
        end
      end
      if (issd) begin
        issued++;
        i_a = rnd256(); i_b = rnd256(); i_tag = 4'($urandom);
      end
    end
    checks++;
    if (issued != 100) begin errors++;
      $display("FAIL stream_count got %0d want 100", issued); end
    test_drain("stream");
  endtask

  task automatic test_backpressure();
    int acc = 0;
    i_ready = 1'b0; i_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      i_a = rnd256(); i_b = rnd256(); i_tag = 4'(c);
      tick();
      if (issd) acc++;
    end
    checks++;
    if (acc != DEP) begin errors++;
      $display("FAIL bp_accepts got %0d want 4", acc); end
    checks++;
    if (o_ready !== 1'b0 || o_credit !== 3'd0) begin errors++;
      $display("FAIL bp_credit got %0b/%0d want 0/0", o_ready, o_credit); end
    checks++;
    if (o_valid !== 1'b1 || o_tag !== 4'(0)) begin errors++;
      $display("FAIL bp_head got %0b/%0h want 1/0", o_valid, o_tag); end
  endtask

  task automatic test_credit_boundary();
    i_valid = 1'b1; i_ready = 1'b1;
    i_a = rnd256(); i_b = rnd256(); i_tag = 4'hA;
    tick();
    checks++;
    if (!popd || issd || got_res !== want_res || got_tag !== want_tag) begin
      errors++;
      $display("FAIL cb_pop got pop=%0b iss=%0b tag=%0h want 1/0/%0h",
               popd, issd, got_tag, want_tag);
    end
    checks++;
    if (o_ready !== 1'b1 || o_credit !== 3'd1) begin errors++;
      $display("FAIL cb_rise got %0b/%0d want 1/1", o_ready, o_credit); end
    i_ready = 1'b0;
    tick();
    checks++;
    if (!issd || o_credit !== 3'd0 || o_ready !== 1'b0) begin errors++;
      $display("FAIL cb_reissue got %0b/%0d want 1/0", issd, o_credit); end
    i_valid = 1'b0; i_ready = 1'b1;
    tick();
    checks++;
    if (popd && (got_res !== want_res || got_tag !== want_tag)) begin
      errors++;
      $display("FAIL cb_pop2 got %0h want %0h", got_tag, want_tag); end
    i_valid = 1'b1; i_tag = 4'hB;
    i_a = rnd256(); i_b = rnd256();
    tick();
    checks++;
    if (!issd || !popd || o_credit !== 3'd1) begin errors++;
      $display("FAIL cb_same got iss=%0b pop=%0b credit=%0d want 1/1/1",
               issd, popd, o_credit); end
    checks++;
    if (got_res !== want_res || got_tag !== want_tag) begin errors++;
      $display("FAIL cb_pop3 got %0h want %0h", got_tag, want_tag); end
    test_drain("cb");
  endtask

  task automatic test_random();
    logic         pv, pr;
    logic [511:0] pres;
    logic [3:0]   ptag;
    pv = 1'b0; pr = 1'b1; pres = '0; ptag = '0;
    for (int c = 0; c < 1000; c++) begin
      i_valid = 1'($urandom); i_ready = 1'($urandom);
      i_a = rnd256(); i_b = rnd256(); i_tag = 4'($urandom);
      checks++;
      if (o_credit !== 3'(DEP - outstanding)) begin errors++;
        $display("FAIL rnd_inv cyc %0d got %0d want %0d",
                 c, o_credit, DEP - outstanding); end
      if (pv && !pr) begin
        checks++;
        if (o_valid !== 1'b1 || o_res !== pres || o_tag !== ptag) begin
          errors++;
          $display("FAIL rnd_hold cyc %0d got %0b/%0h want 1/%0h",
                   c, o_valid, o_tag, ptag);
        end
      end
      pv = o_valid; pr = i_ready; pres = o_res; ptag = o_tag;
      tick();
      if (popd) begin
        checks++;
        if (sb_miss || got_res !== want_res || got_tag !== want_tag) begin
          errors++;
          $display("FAIL rnd_pop got %0h/%0h want %0h/%0h",
                   got_res, got_tag, want_res, want_tag);
        end
      end
    end
    test_drain("rnd");
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    i_ready = 1'b0; i_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      i_a = rnd256(); i_b = rnd256(); i_tag = 4'(c + 1);
      tick();
    end
    i_valid = 1'b0;
    repeat (LAT + 1) tick();
    i_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      i_a = rnd256(); i_b = rnd256(); i_tag = 4'(c + 3);
      tick();
    end
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_credit !== 3'd0) begin errors++;
      $display("FAIL rm_pre got %0b/%0d want 1/0", o_valid, o_credit); end
    rstn = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_credit !== 3'd4 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_async got %0b/%0d/%0b want 0/4/1",
               o_valid, o_credit, o_ready);
    end
    q_res.delete(); q_tag.delete(); outstanding = 0;
    @(negedge clk);
    rstn = 1'b1;
    i_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (o_valid) stale++;
      tick();
    end
    checks++;
    if (stale != 0 || o_credit !== 3'd4) begin errors++;
      $display("FAIL rm_stale got %0d/%0d want 0/4", stale, o_credit); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_credit_boundary();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
